// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states, default sizes and the divide-by-zero quotient constant.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = MDU_WIDTH;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PREP = 2'b01,
        S_CALC = 2'b10,
        S_FIX  = 2'b11
    } state_t;

    // Quotient reported for a zero divisor; wide enough for any WIDTH <= 64.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath built around a single
// WIDTH+1-bit adder.
//   multiply: part + (mq_bit ? opnd : 0), result shifted right one place;
//             out_bit is the bit that drops into the low product half.
//   divide:   trial subtract of opnd from {part, mq_bit}; out_bit is the
//             quotient bit and next_part the restored or reduced remainder.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] part,
    input  logic             mq_bit,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] next_part,
    output logic             out_bit
);

    logic [WIDTH:0] add_a;
    logic [WIDTH:0] add_b;
    logic [WIDTH:0] sum;
    logic           qbit;

    // Shared adder: subtraction is a + ~b + 1, so carry-in is is_div.
    always_comb begin
        if (is_div) begin
            add_a = {part, mq_bit};
            add_b = ~{1'b0, opnd};
        end else begin
            add_a = {1'b0, part};
            add_b = mq_bit ? {1'b0, opnd} : '0;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, is_div};
    end

    // A clear top bit after the trial subtract means the divisor fitted.
    always_comb begin
        qbit = ~sum[WIDTH];
        if (is_div) begin
            next_part = qbit ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
            out_bit   = qbit;
        end else begin
            next_part = sum[WIDTH:1];
            out_bit   = sum[0];
        end
    end

endmodule

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are reduced to magnitudes, run through ITER shift/add or
// shift/subtract steps, then sign-corrected when HI/LO are written.
// Optional build macro MDU_ABORT_EN adds an abort input that cancels a
// running operation without touching HI/LO.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int ITER  = MDU_ITER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
`ifdef MDU_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW       = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(ITER - 1);

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   src_a;     // raw rs, kept for the divide-by-zero HI
    logic [WIDTH-1:0]   opnd;      // raw rt until PREP, then the step operand
    logic [WIDTH-1:0]   part;      // product high half / running remainder
    logic [WIDTH-1:0]   mq;        // multiplier->product low / dividend->quotient
    logic [CW-1:0]      cnt;
    logic               neg_q;     // negate product or quotient
    logic               rem_neg;   // negate remainder (follows dividend sign)
    logic               div0;

    logic               is_div;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               step_in;
    logic [WIDTH-1:0]   step_part;
    logic               step_bit;

    // Operand decode and magnitude formation, consumed in PREP.
    always_comb begin
        is_div    = op_q[1];
        is_signed = ~op_q[0];
        a_neg     = is_signed & src_a[WIDTH-1];
        b_neg     = is_signed & opnd[WIDTH-1];
        a_mag     = a_neg ? -src_a : src_a;
        b_mag     = b_neg ? -opnd  : opnd;
        // Multiply consumes the multiplier LSB-first, divide the dividend MSB-first.
        step_in   = is_div ? mq[WIDTH-1] : mq[0];
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div    (is_div),
        .part      (part),
        .mq_bit    (step_in),
        .opnd      (opnd),
        .next_part (step_part),
        .out_bit   (step_bit)
    );

    // Control FSM, datapath registers and HI/LO writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            op_q    <= OP_MULT;
            src_a   <= '0;
            opnd    <= '0;
            part    <= '0;
            mq      <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            rem_neg <= 1'b0;
            div0    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
`ifdef MDU_ABORT_EN
            if (abort && state != S_IDLE) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else
`endif
            begin
                case (state)
                    S_IDLE: begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                        if (start) begin
                            op_q  <= op;
                            src_a <= rs;
                            opnd  <= rt;
                            busy  <= 1'b1;
                            state <= S_PREP;
                        end
                    end
                    S_PREP: begin
                        part    <= '0;
                        cnt     <= '0;
                        mq      <= is_div ? a_mag : b_mag;
                        opnd    <= is_div ? b_mag : a_mag;
                        neg_q   <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        div0    <= is_div && (opnd == '0);
                        state   <= S_CALC;
                    end
                    S_CALC: begin
                        part <= step_part;
                        if (is_div) mq <= {mq[WIDTH-2:0], step_bit};
                        else        mq <= {step_bit, mq[WIDTH-1:1]};
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_LAST) state <= S_FIX;
                    end
                    S_FIX: begin
                        if (is_div) begin
                            if (div0) begin
                                lo <= DIV0_QUOT[WIDTH-1:0];
                                hi <= src_a;
                            end else begin
                                lo <= neg_q   ? -mq   : mq;
                                hi <= rem_neg ? -part : part;
                            end
                        end else begin
                            {hi, lo} <= neg_q ? -{part, mq} : {part, mq};
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu: the driver pushes expected HI/LO and done
// cycle into a queue, an independent monitor pops on every done pulse.
module tb_hilo_mdu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_ABORT_EN
    logic        abort;
`endif

    hilo_mdu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
`ifdef MDU_ABORT_EN
        .abort (abort),
`endif
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic push, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rs = $urandom; rt = $urandom; op = 2'($urandom);
        if (push) begin
            e.hi = eh; e.lo = el; e.cyc = cyc + 34;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("busy_timeout", 64'(n), 64'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        issue(o, a, b, 1'b1, eh, el);
        wait_idle();
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 64'(cyc), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("hi", 64'(hi), 64'(e.hi));
                    chk("lo", 64'(lo), 64'(e.lo));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] hsave, lsave;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
`ifdef MDU_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // mthi / mtlo in IDLE
        hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        chk("mthi", 64'(hi), 64'h1234);
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h5678);

        // MULTU max*max with busy length and an ignored mthi while busy
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 3) begin hi_we = 1'b1; wdata = 32'hDEAD; end
            else hi_we = 1'b0;
            @(negedge clk);
            if (n == 3) chk("mthi_busy_ignored", 64'(hi), 64'h1234);
        end
        hi_we = 1'b0;
        chk("busy_cycles", 64'(n), 64'd34);

        run(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run(2'b00, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
        run(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run(2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
        run(2'b10, 32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run(2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
        run(2'b10, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF);

        // Second start mid-operation is ignored; start in the done cycle is taken.
        issue(2'b01, 32'h12345678, 32'h00000010, 1'b1, 32'h00000001, 32'h23456780);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd1; rt = 32'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) chk("done_timeout", 64'(n), 64'd0);
        issue(2'b01, 32'd3, 32'd5, 1'b1, 32'h0, 32'd15);
        wait_idle();

        // Reset in the middle of a DIV: immediate clear, no done afterwards.
        issue(2'b10, 32'd1000, 32'd7, 1'b0, 32'h0, 32'h0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

`ifdef MDU_ABORT_EN
        run(2'b01, 32'd6, 32'd7, 32'h0, 32'd42);
        hsave = hi; lsave = lo;
        issue(2'b01, 32'h1111, 32'd2, 1'b0, 32'h0, 32'h0);
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'(hsave));
        chk("abort_lo", 64'(lo), 64'(lsave));
        repeat (40) @(negedge clk);
`else
        hsave = '0; lsave = '0;
        chk("post_rst_hilo", {hi, lo}, {hsave, lsave});
`endif

        chk("pending_expectations", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hilo_mdu.md
Name: hilo_mdu

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. Executes MULT, MULTU, DIV and DIVU.
- Sits downstream of the decode/register-file read stage. Consumes rs/rt operands and feeds mfhi/mflo results back into the writeback mux.
- Each iteration reuses one 32-bit add/subtract step instead of a combinational array.

Parameters:
- WIDTH, 32, operand and HI/LO width. The design is verified at 32 only.
- ITER, WIDTH, number of shift/add or shift/subtract iterations.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only while in IDLE
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs  in  WIDTH  multiplicand / dividend
- rt  in  WIDTH  multiplier / divisor
- hi_we  in  1  mthi write strobe
- lo_we  in  1  mtlo write strobe
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  high while the operation is not IDLE
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: clk, one clock; rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation abandons the operation with no done pulse.
- FSM states: IDLE, PREP, CALC, FIX.
  - IDLE + start=1 (edge E0): latch op, rs and rt; go to PREP.
  - PREP (edge E1): form operand magnitudes for signed ops; record result signs; clear the partial register; counter=0; go to CALC.
  - CALC (edges E2..E33): one iteration per edge; counter increments; after counter reaches ITER-1, go to FIX.
  - FIX (edge E34): apply sign correction; write hi/lo; done=1 for exactly one cycle; go to IDLE.
- Latency: results are visible and done=1 in the cycle after E34, i.e. ITER+2 edges after start is sampled. busy=1 from after E0 until E34.
- Multiply: unsigned shift-add over the magnitudes giving a 2*WIDTH product. HI=upper half, LO=lower half. MULT negates the 64-bit product when the operand signs differ.
- Divide: restoring shift-subtract. LO=quotient, HI=remainder.
  - DIV quotient is truncated toward zero; the remainder takes the sign of the dividend.
- Divide by zero (rt=0, DIV or DIVU): same latency; LO=all ones, HI=rs unmodified; no sign correction.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- start while busy is ignored; no queueing.
- start asserted in the same cycle as done is accepted, because the state is already IDLE.
- hi_we/lo_we:
  - Honoured only in IDLE.
  - If asserted together with an accepted start, the write occurs at E0 and is later overwritten at E34.
  - Ignored while busy.
- rs/rt/op may change after E0 without effect.

Optional Feature:
- Macro: MDU_ABORT_EN.
- With the macro defined:
  - Adds input port abort (1 bit).
  - If busy=1 and abort=1 at an edge, state returns to IDLE at that edge. hi/lo are unchanged and no done pulse is produced.
  - abort in IDLE has no effect.
  - abort and FIX at the same edge: abort wins and hi/lo are not written.
- Without the macro: the abort port does not exist, and an operation always runs to completion unless rst_n is asserted.

Decomposition:
- Package mdu_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state typedef/encodings
  - ITER default
  - DIV0_QUOT constant (all ones)
- One sub-module, mdu_step: a combinational WIDTH+1-bit add/subtract step. It selects add (multiply) or trial subtract (divide) and outputs the next partial/remainder and quotient bit. It is instantiated once in hilo_mdu; counter, FSM and HI/LO registers stay in the top.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done exactly 34 edges after start; busy high for 34 cycles.
- MULT rs=0xFFFFFFFD (-3) rt=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU rs=7 rt=2 -> lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, same latency.
- Second start at edge 10 of a running MULTU is ignored. Result and done timing are unchanged, and the next start is accepted in the done cycle.
- rst_n low at edge 20 of a DIV -> immediately hi=lo=0, busy=0, no done pulse.
- With MDU_ABORT_EN: abort at edge 15 -> IDLE, hi/lo unchanged, no done.
- mthi/mtlo: wdata=0x1234 with hi_we=1 in IDLE -> hi=0x1234 next edge; the same strobe while busy is ignored.
